// File: rtl/psum_drain_ctrl_pkg.sv
// Shared sizing defaults and FSM encoding for the psum drain controller.
package psum_drain_ctrl_pkg;

    localparam int PE_COL_DEF   = 8;
    localparam int BIT_ADDR_DEF = 10;
    localparam int BIT_PSUM_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WB = 2'd1,
        ST_READ    = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    // Bank index width; a single bank still gets a 1-bit field.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Drain control, SRAM B-port and output stream signals.
// Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_valid and the payload hold.
interface psum_drain_ctrl_if
    import psum_drain_ctrl_pkg::*;
#(
    parameter int PE_COL   = PE_COL_DEF,
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_PSUM = BIT_PSUM_DEF
);
    localparam int BIT_BANK = bank_w(PE_COL);

    logic                         start;
    logic [BIT_ADDR-1:0]          base_addr;
    logic [BIT_ADDR-1:0]          num_rows;
    logic                         wb_active;
    logic                         busy;
    logic                         done;
    logic [PE_COL-1:0]            sram_psum_en_b;
    logic [PE_COL*BIT_ADDR-1:0]   sram_psum_addr_b;
    logic [PE_COL*BIT_PSUM-1:0]   sram_psum_dout_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [BIT_PSUM-1:0]          out_data;
    logic [BIT_BANK-1:0]          out_bank;
    logic [BIT_ADDR-1:0]          out_addr;
    logic                         out_last;

    modport master (
        input  start, base_addr, num_rows, wb_active, sram_psum_dout_b, out_ready,
        output busy, done, sram_psum_en_b, sram_psum_addr_b,
               out_valid, out_data, out_bank, out_addr, out_last
    );

    modport slave (
        output start, base_addr, num_rows, wb_active, sram_psum_dout_b, out_ready,
        input  busy, done, sram_psum_en_b, sram_psum_addr_b,
               out_valid, out_data, out_bank, out_addr, out_last
    );

endinterface

// File: rtl/psum_drain_fifo.sv
// Two-entry synchronous FIFO with occupancy count; push and pop may coincide.
module psum_drain_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains every psum bank over the SRAM B port, address-major / bank-minor,
// into a 2-deep output stream once the write path has gone quiet.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int PE_COL   = PE_COL_DEF,
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_PSUM = BIT_PSUM_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    psum_drain_ctrl_if.master    bus,
    output state_e               o_dbg_state
);
    localparam int BIT_BANK = bank_w(PE_COL);
    localparam int FIFO_W   = BIT_PSUM + BIT_BANK + BIT_ADDR + 1;

    state_e                r_state;
    state_e                w_next_state;
    logic                  r_quiet;
    logic [BIT_ADDR-1:0]   r_base;
    logic [BIT_ADDR-1:0]   r_rows;
    logic [BIT_ADDR-1:0]   r_row;
    logic [BIT_BANK-1:0]   r_bank;
    logic                  r_inflight;
    logic [BIT_BANK-1:0]   r_inf_bank;
    logic [BIT_ADDR-1:0]   r_inf_addr;
    logic                  r_inf_last;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_finish;
    logic                  w_last_rd;
    logic                  w_room;
    logic                  w_drained;
    logic [BIT_ADDR-1:0]   w_rd_addr;
    logic [BIT_PSUM-1:0]   w_ret_data;
    logic [FIFO_W-1:0]     w_ret_entry;
    logic [FIFO_W-1:0]     w_fifo_dout;
    logic [FIFO_W-1:0]     w_head;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic                  w_out_valid;
    logic                  w_pop;

    assign w_rd_addr  = r_base + r_row;
    assign w_last_rd  = (r_bank == BIT_BANK'(PE_COL - 1)) && (r_row == r_rows - BIT_ADDR'(1));
    assign w_room     = (w_fifo_count + {1'b0, r_inflight}) < 2'd2;
    assign w_ret_data = bus.sram_psum_dout_b[r_inf_bank*BIT_PSUM +: BIT_PSUM];
    assign w_ret_entry = {w_ret_data, r_inf_bank, r_inf_addr, r_inf_last};

    // Returning read bypasses the FIFO when it is empty, so data leaves the
    // cycle it arrives and one word per cycle is sustained.
    assign w_out_valid = (w_fifo_count != 2'd0) || r_inflight;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_fifo_pop  = w_pop && (w_fifo_count != 2'd0);
    assign w_fifo_push = r_inflight && !((w_fifo_count == 2'd0) && w_pop);
    assign w_drained   = (w_fifo_count + {1'b0, r_inflight}) == {1'b0, w_pop};

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next_state = ST_WAIT_WB;
            end
            ST_WAIT_WB: begin
                if (!bus.wb_active && r_quiet) w_next_state = ST_READ;
            end
            ST_READ: begin
                if (r_rows == '0) begin
                    w_next_state = ST_FLUSH;
                end else if (w_room) begin
                    w_issue = 1'b1;
                    if (w_last_rd) w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_drained) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quiet    <= 1'b0;
            r_base     <= '0;
            r_rows     <= '0;
            r_row      <= '0;
            r_bank     <= '0;
            r_inflight <= 1'b0;
            r_inf_bank <= '0;
            r_inf_addr <= '0;
            r_inf_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= w_finish;
            r_inflight <= w_issue;
            // r_quiet marks that the previous WAIT_WB cycle already saw wb_active low.
            r_quiet    <= (r_state == ST_WAIT_WB) && !bus.wb_active;
            if ((r_state == ST_IDLE) && bus.start) begin
                r_base <= bus.base_addr;
                r_rows <= bus.num_rows;
                r_row  <= '0;
                r_bank <= '0;
            end
            if (w_issue) begin
                r_inf_bank <= r_bank;
                r_inf_addr <= w_rd_addr;
                r_inf_last <= w_last_rd;
                if (r_bank == BIT_BANK'(PE_COL - 1)) begin
                    r_bank <= '0;
                    r_row  <= r_row + BIT_ADDR'(1);
                end else begin
                    r_bank <= r_bank + BIT_BANK'(1);
                end
            end
        end
    end

    always_comb begin
        bus.sram_psum_en_b   = '0;
        bus.sram_psum_addr_b = '0;
        if (w_issue) begin
            bus.sram_psum_en_b[r_bank]                        = 1'b1;
            bus.sram_psum_addr_b[r_bank*BIT_ADDR +: BIT_ADDR] = w_rd_addr;
        end
    end

    psum_drain_fifo #(.W(FIFO_W)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_fifo_push),
        .i_din   (w_ret_entry),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_head = '0;
        if (w_fifo_count != 2'd0) w_head = w_fifo_dout;
        else if (r_inflight)      w_head = w_ret_entry;
    end

    assign {bus.out_data, bus.out_bank, bus.out_addr, bus.out_last} = w_head;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl: 4 banks, bank-valued SRAM model, scoreboard queue.
module tb_psum_drain_ctrl;
    import psum_drain_ctrl_pkg::*;

    localparam int PE_COL   = 4;
    localparam int BIT_ADDR = 10;
    localparam int BIT_PSUM = 32;
    localparam int BIT_BANK = 2;
    localparam int BEAT_W   = BIT_BANK + BIT_ADDR + BIT_PSUM + 1;
    localparam int MAXC     = 600;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;

    always #5 clk = ~clk;

    psum_drain_ctrl_if #(.PE_COL(PE_COL), .BIT_ADDR(BIT_ADDR), .BIT_PSUM(BIT_PSUM)) bus ();

    psum_drain_ctrl #(.PE_COL(PE_COL), .BIT_ADDR(BIT_ADDR), .BIT_PSUM(BIT_PSUM)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // SRAM model: word = bank*100 + addr, registered read.
    logic [PE_COL*BIT_PSUM-1:0] sram_q = '0;
    assign bus.sram_psum_dout_b = sram_q;
    always @(posedge clk) begin
        for (int b = 0; b < PE_COL; b++) begin
            if (bus.sram_psum_en_b[b])
                sram_q[b*BIT_PSUM +: BIT_PSUM] <= BIT_PSUM'(b*100)
                    + BIT_PSUM'(bus.sram_psum_addr_b[b*BIT_ADDR +: BIT_ADDR]);
        end
    end

    // Scoreboard and bookkeeping
    logic [BEAT_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc, beat_cnt, done_cnt, done_cyc;
    int first_en_cyc, first_valid_cyc, last_valid_cyc;
    int wb_len, stray_cyc, cur_rows;
    logic busy_c1, busy_at_done, rnd_ready, prev_stall;
    logic [BEAT_W-1:0] prev_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [BEAT_W-1:0] beat;
        logic [BEAT_W-1:0] exp_beat;
        logic [PE_COL*BIT_ADDR-1:0] addr_other;
        @(negedge clk);
        beat = {bus.out_bank, bus.out_addr, bus.out_data, bus.out_last};
        if (prev_stall) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_payload", 64'(beat), 64'(prev_beat));
        end
        check("en_onehot0", 64'($onehot0(bus.sram_psum_en_b)), 64'd1);
        addr_other = bus.sram_psum_addr_b;
        for (int b = 0; b < PE_COL; b++)
            if (bus.sram_psum_en_b[b]) addr_other[b*BIT_ADDR +: BIT_ADDR] = '0;
        check("addr_unselected", 64'(addr_other), 64'd0);
        if (cyc == 1) busy_c1 = bus.busy;
        if (bus.out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
        end
        if ((bus.sram_psum_en_b != '0) && (first_en_cyc < 0)) first_en_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = bus.busy;
        end
        if (bus.out_valid && bus.out_ready) begin
            beat_cnt++;
            if (exp_q.size() > 0) begin
                exp_beat = exp_q.pop_front();
                check("beat", 64'(beat), 64'(exp_beat));
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_beat  = beat;
        @(posedge clk);
        #1;
        cyc++;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step();
        cycle();
        bus.start     = (cyc == stray_cyc);
        bus.wb_active = (cyc <= wb_len);
    endtask

    task automatic start_drain(input int base, input int rows, input int wb, input logic rnd, input int stray);
        logic [BIT_ADDR-1:0] a;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < PE_COL; b++) begin
                a = BIT_ADDR'(base) + BIT_ADDR'(r);
                exp_q.push_back({BIT_BANK'(b), a, BIT_PSUM'(b*100) + BIT_PSUM'(a),
                                 1'((r == rows - 1) && (b == PE_COL - 1))});
            end
        end
        beat_cnt = 0; done_cnt = 0; done_cyc = -1; cyc = 0;
        first_en_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
        busy_c1 = 1'b0; busy_at_done = 1'b1; prev_stall = 1'b0;
        wb_len = wb; stray_cyc = stray; cur_rows = rows; rnd_ready = rnd;
        bus.out_ready = 1'b1;
        bus.base_addr = BIT_ADDR'(base);
        bus.num_rows  = BIT_ADDR'(rows);
        bus.wb_active = (wb > 0);
        bus.start     = 1'b1;
    endtask

    task automatic finish_drain(input string name);
        int n;
        int fe;
        n  = PE_COL * cur_rows;
        fe = (wb_len > 0) ? wb_len + 3 : 3;
        while (done_cnt == 0 && cyc < MAXC) step();
        check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
        repeat (4) step();
        check({name, "_busy_c1"}, 64'(busy_c1), 64'd1);
        check({name, "_beats"}, 64'(beat_cnt), 64'(n));
        check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({name, "_idle"}, 64'(dbg_state), 64'(ST_IDLE));
        if (!rnd_ready) begin
            if (n > 0) begin
                check({name, "_first_en"}, 64'(first_en_cyc), 64'(fe));
                check({name, "_first_valid"}, 64'(first_valid_cyc), 64'(fe + 1));
                check({name, "_last_valid"}, 64'(last_valid_cyc), 64'(fe + n));
                check({name, "_done_cyc"}, 64'(done_cyc), 64'(fe + n + 1));
            end else begin
                check({name, "_no_en"}, 64'(first_en_cyc), -64'sd1);
                check({name, "_no_valid"}, 64'(first_valid_cyc), -64'sd1);
                check({name, "_done_cyc"}, 64'(done_cyc), 64'd5);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.wb_active = 1'b0; bus.out_ready = 1'b1;
        bus.base_addr = '0; bus.num_rows = '0;
        rnd_ready = 1'b0; prev_stall = 1'b0; cyc = 100; stray_cyc = -1; wb_len = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_en", 64'(bus.sram_psum_en_b), 64'd0);
        check("rst_addr_b", 64'(bus.sram_psum_addr_b), 64'd0);
        check("rst_payload", 64'({bus.out_data, bus.out_bank, bus.out_addr}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        start_drain(5, 2, 0, 1'b0, -1);       finish_drain("basic");
        start_drain(0, 1, 10, 1'b0, -1);      finish_drain("wb_gate");
        start_drain(100, 3, 0, 1'b1, -1);     finish_drain("backpressure");
        start_drain(1022, 4, 0, 1'b0, -1);    finish_drain("wrap");
        start_drain(0, 0, 0, 1'b0, -1);       finish_drain("zero_rows");
        start_drain(20, 2, 0, 1'b0, 5);       finish_drain("stray_start");

        // Reset in the middle of a drain, then a clean restart.
        start_drain(40, 2, 0, 1'b0, -1);
        while (beat_cnt < 3 && cyc < MAXC) step();
        check("mid_beats", 64'(beat_cnt), 64'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_en", 64'(bus.sram_psum_en_b), 64'd0);
        check("mid_rst_payload", 64'({bus.out_data, bus.out_bank, bus.out_addr, bus.out_last}), 64'd0);
        exp_q.delete();
        done_cnt   = 0;
        prev_stall = 1'b0;
        repeat (3) step();
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        start_drain(7, 1, 0, 1'b0, -1);       finish_drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_drain_ctrl.md
# psum_drain_ctrl

Sequences readout of the partial-sum SRAM banks once a systolic pass has finished writing them. It waits for the psum write path to go quiet, then reads every bank over the SRAM B port, address-major and bank-minor. Results stream out on a valid/ready interface for host or post-processing logic. It sits beside the psum write loader, which owns the A port of the same banks.

## Interface
- PE_COL, 8, number of psum banks (= `PE_COL`)
- BIT_ADDR, 10, per-bank address width (= `BIT_ADDR`)
- BIT_PSUM, 32, psum word width (= `BIT_PSUM`)
- CLK  in  1  sole clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  request a drain; sampled only in IDLE
- base_addr  in  BIT_ADDR  first address, captured on accepted start
- num_rows  in  BIT_ADDR  addresses per bank to drain, captured on accepted start
- wb_active  in  1  OR of the systolic psum valids (write path busy)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the drain completes
- sram_psum_en_b  out  PE_COL  per-bank read enable, one-hot or zero
- sram_psum_addr_b  out  PE_COL*BIT_ADDR  per-bank read address; non-selected slices driven 0
- sram_psum_dout_b  in  PE_COL*BIT_PSUM  per-bank read data, valid 1 cycle after enable
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  BIT_PSUM  psum word
- out_bank  out  $clog2(PE_COL)  source bank
- out_addr  out  BIT_ADDR  source address
- out_last  out  1  marks the final word of the drain

## Operation
- States:
  - IDLE -> WAIT_WB on start.
  - WAIT_WB -> READ after wb_active has been low for 2 consecutive cycles. This covers the loader register stage plus the SRAM write.
  - READ -> FLUSH after the last read is issued.
  - FLUSH -> IDLE once the FIFO is empty and no read is in flight. done pulses on this transition.
- num_rows = 0: the block still passes through WAIT_WB, issues no reads, then goes to FLUSH and pulses done. No output beats are produced.
- Read order:
  - Bank counter b runs 0..PE_COL-1.
  - On wrap of b, row counter r increments.
  - Read address = base_addr + r, modulo 2^BIT_ADDR (wraps silently).
- Read issue in READ requires fifo_count + inflight < 2. The output FIFO is 2 entries deep and holds {data, bank, addr, last}.
- Read return: one cycle after issue, the selected bank's slice of sram_psum_dout_b is pushed into the FIFO, together with the bank, address and last tag registered at issue time.
- Pop occurs when out_valid && out_ready. A push and a pop in the same cycle are both honoured.
- out_data, out_bank, out_addr and out_last hold stable while out_valid is high and out_ready is low.
- start while busy is ignored.
- wb_active rising during READ or FLUSH is not checked. Keeping write traffic quiet during a drain is the upstream owner's responsibility.

## Timing
- Reset values:
  - State IDLE; counters, FIFO and inflight cleared.
  - busy, done, out_valid and out_last are 0.
  - sram_psum_en_b, sram_psum_addr_b, out_data, out_bank and out_addr are 0.
- Reset asserted mid-drain aborts immediately: the FIFO is dropped, no done pulse is produced, and out_valid falls asynchronously.
- Sequence from start:
  - start high in cycle 0 -> busy high in cycle 1.
  - With wb_active low throughout, the first read enable is in cycle 3 and the first out_valid is in cycle 4.
- Throughput: one word per cycle while out_ready is held high.
- Total drain with out_ready high: last out_valid at cycle 3 + PE_COL*num_rows. done pulses in the cycle after the last beat is accepted.
- Backpressure: with out_ready low, at most 2 words are buffered and reads stall. No SRAM read is ever dropped or repeated.

## Structure
- Shared package/header (param.v): PE_COL, BIT_ADDR, BIT_PSUM, and the state encoding localparams (IDLE, WAIT_WB, READ, FLUSH).
- Sub-module psum_drain_fifo: a 2-entry synchronous FIFO with count output and simultaneous push/pop. Used once, instantiated in the controller.
- The controller holds the FSM, the quiet counter, the bank/row counters, the inflight flag and the SRAM port drive.

## Test plan
- Basic drain:
  - Stimulus: PE_COL=4, base_addr=5, num_rows=2, banks preloaded with value = bank*100 + addr, out_ready held 1.
  - Required response: 8 beats in the order (b0,a5)=5, (b1,a5)=105, ..., (b3,a6)=306. out_last is set on the 8th beat only, done follows 1 cycle after the 8th beat, and busy falls with done.
- Write-path gating:
  - Stimulus: wb_active high for 10 cycles after start.
  - Required response: no sram_psum_en_b until 2 cycles after wb_active falls.
- Backpressure:
  - Stimulus: toggle out_ready pseudo-randomly.
  - Required response: all PE_COL*num_rows words are delivered exactly once, in order, and the payload is stable while stalled.
- Address wrap:
  - Stimulus: base_addr=1022, num_rows=4.
  - Required response: addresses seen are 1022, 1023, 0, 1.
- Zero-length and stray start:
  - Stimulus: num_rows=0; separately, a second start pulsed mid-drain.
  - Required response: num_rows=0 gives a done pulse with no out_valid. The mid-drain start is ignored and the beat count is unchanged.
- Reset mid-drain:
  - Stimulus: assert RST after 3 beats.
  - Required response: all outputs go to 0 and no done pulse. A fresh start afterwards drains correctly from r=0, b=0.
